wb_spi_flash_reader: RTL and testbench



---
 rtl/spi_flash_pkg.sv | 24 ++
 rtl/spi_sck_gen.sv | 43 ++++
 rtl/wb_spi_flash_reader.sv | 158 +++++++++++++++
 tb/tb_wb_spi_flash_reader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the Wishbone SPI-flash read bridge.
// Contents: FSM state type, default READ opcode, SPI frame length,
// and the little-endian packing helper used when a word completes.
package spi_flash_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] READ_CMD_DEFAULT = 8'h03;
    localparam int         FRAME_BITS       = 64;
    // First half of the frame is command+address out, second half data in.
    localparam int         HALF_BITS        = FRAME_BITS / 2;

    // Bytes arrive first-byte-first in rx[31:24]; the flash is little-endian,
    // so the first byte belongs in [7:0]. Bit order inside a byte is kept.
    function automatic logic [31:0] le_pack(input logic [31:0] rx);
        return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI serial-clock generator.
// Ports:
//   i_clk   system clock
//   i_rst   synchronous active-high reset
//   i_en    run enable; when low the divider is cleared and sck held low
//   o_sck   serial clock, idles low (SPI mode 0)
//   o_rise  one-cycle strobe: sck goes high on the coming clock edge
//   o_fall  one-cycle strobe: sck goes low on the coming clock edge
module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);

    logic [7:0] r_cnt;
    logic       r_sck;
    logic       w_tick;

    // Each sck phase lasts CLK_DIV cycles; tick marks the last cycle of a phase.
    assign w_tick = i_en && (r_cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_sck  = r_sck;
    assign o_rise = w_tick && !r_sck;
    assign o_fall = w_tick &&  r_sck;

endmodule

// File: rtl/wb_spi_flash_reader.sv
// Wishbone B4 classic read-only slave backed by a serial NOR flash.
// Every read issues READ_CMD plus a 24-bit word-aligned address in SPI
// mode 0, shifts in 32 data bits and terminates with a one-cycle ack.
// Writes terminate with a one-cycle err and no SPI traffic.
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wb_adr_i, wb_dat_i,
//   wb_sel_i, wb_we_i,
//   wb_cyc_i, wb_stb_i          Wishbone request (dat_i/sel_i unused)
//   wb_dat_o, wb_ack_o,
//   wb_err_o                    Wishbone response
//   spi_sck_o, spi_cs_n_o,
//   spi_mosi_o, spi_miso_i      flash pins
module wb_spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int         CLK_DIV   = 2,
    parameter logic [7:0] READ_CMD  = READ_CMD_DEFAULT,
    parameter int         ADDR_BITS = 24
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        spi_sck_o,
    output logic        spi_cs_n_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_tx;
    logic [31:0] r_rx;
    logic [31:0] r_dat;
    logic [5:0]  r_bit;
    logic        r_live;

    logic        w_bus;
    logic        w_req;
    logic        w_sck;
    logic        w_rise;
    logic        w_fall;
    logic        w_last;
    logic        w_rx_phase;
    logic [23:0] w_addr;
    logic        w_unused;

    assign w_bus      = wb_cyc_i && wb_stb_i;
    assign w_req      = (r_state == IDLE) && w_bus;
    assign w_last     = w_fall && (r_bit == LAST_BIT);
    assign w_rx_phase = (r_bit >= 6'(HALF_BITS));
    // Word aligned; bits above ADDR_BITS alias.
    assign w_addr     = 24'({wb_adr_i[ADDR_BITS-1:2], 2'b00});
    assign w_unused   = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:ADDR_BITS], wb_adr_i[1:0]};

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .i_clk  (wb_clk_i),
        .i_rst  (wb_rst_i),
        .i_en   (r_state == SHIFT),
        .o_sck  (w_sck),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        wb_ack_o    = 1'b0;
        wb_err_o    = 1'b0;
        spi_cs_n_o  = 1'b1;
        spi_mosi_o  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_nxt = wb_we_i ? ERR : SHIFT;
                end
            end
            SHIFT: begin
                spi_cs_n_o = 1'b0;
                // Data phase keeps MOSI low; tx shifts only on sck falls.
                spi_mosi_o = !w_rx_phase && r_tx[31];
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // Abandoned cycles still finish the frame but are not acked.
                wb_ack_o    = r_live;
                w_state_nxt = IDLE;
            end
            ERR: begin
                wb_err_o    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_bit  <= '0;
            r_live <= 1'b0;
            r_dat  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req && !wb_we_i) begin
                        r_tx   <= {READ_CMD, w_addr};
                        r_bit  <= '0;
                        r_live <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!w_bus) begin
                        r_live <= 1'b0;
                    end
                    if (w_rise && w_rx_phase) begin
                        r_rx <= {r_rx[30:0], spi_miso_i};
                    end
                    if (w_fall) begin
                        r_tx  <= {r_tx[30:0], 1'b0};
                        r_bit <= r_bit + 6'd1;
                        if (w_last && r_live && w_bus) begin
                            r_dat <= le_pack(r_rx);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wb_dat_o  = r_dat;
    assign spi_sck_o = w_sck;

endmodule

// File: tb/tb_wb_spi_flash_reader.sv
// Bench for wb_spi_flash_reader: instance 0 runs CLK_DIV=2, instance 1 CLK_DIV=1.
// A behavioural SPI flash per instance decodes the MOSI frame and answers
// from a small byte map; expected words are queued when a read is issued
// and compared when the DUT acks.
module tb_wb_spi_flash_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0][31:0] adr;
    logic [31:0]      wdat;
    logic [3:0]       sel;
    logic [1:0]       we, cyc, stb;
    logic [1:0][31:0] dat_o;
    logic [1:0]       ack, err, sck, csn, mosi;
    logic [1:0]       miso = 2'b00;

    int          total = 0;
    int          bad   = 0;

    int          rises [2] = '{0, 0};
    int          acks  [2] = '{0, 0};
    int          errs  [2] = '{0, 0};
    int          mosi_hi [2] = '{0, 0};
    int          nbit  [2] = '{0, 0};
    logic [31:0] frame [2] = '{32'h0, 32'h0};
    logic [1:0]  psck = 2'b00;

    typedef struct {
        int          g;
        logic [31:0] frame;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wb_spi_flash_reader #(
            .CLK_DIV (g == 0 ? 2 : 1)
        ) u_dut (
            .wb_clk_i   (clk),
            .wb_rst_i   (rst),
            .wb_adr_i   (adr[g]),
            .wb_dat_i   (wdat),
            .wb_sel_i   (sel),
            .wb_we_i    (we[g]),
            .wb_cyc_i   (cyc[g]),
            .wb_stb_i   (stb[g]),
            .wb_dat_o   (dat_o[g]),
            .wb_ack_o   (ack[g]),
            .wb_err_o   (err[g]),
            .spi_sck_o  (sck[g]),
            .spi_cs_n_o (csn[g]),
            .spi_mosi_o (mosi[g]),
            .spi_miso_i (miso[g])
        );
    end

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'h000104: return 8'hEF;
            24'h000105: return 8'hBE;
            24'h000106: return 8'hAD;
            24'h000107: return 8'hDE;
            default:    return a[7:0] ^ a[15:8] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [23:0] b;
        b = {a[23:2], 2'b00};
        return {fbyte(b + 24'd3), fbyte(b + 24'd2), fbyte(b + 24'd1), fbyte(b)};
    endfunction

    // Flash model, sampled on the falling clock edge when DUT pins are stable.
    always @(negedge clk) begin
        int         k;
        logic [7:0] fb;
        for (int g = 0; g < 2; g++) begin
            if (sck[g] && !psck[g]) begin
                rises[g] <= rises[g] + 1;
                if (nbit[g] < 32) frame[g] <= {frame[g][30:0], mosi[g]};
                else if (mosi[g]) mosi_hi[g] <= mosi_hi[g] + 1;
                nbit[g] <= nbit[g] + 1;
            end
            if (!sck[g] && psck[g] && nbit[g] >= 32 && nbit[g] < 64) begin
                k  = nbit[g] - 32;
                fb = fbyte(frame[g][23:0] + 24'(k / 8));
                miso[g] <= fb[3'(7 - (k % 8))];
            end
            if (csn[g]) nbit[g] <= 0;
            if (ack[g]) acks[g] <= acks[g] + 1;
            if (err[g]) errs[g] <= errs[g] + 1;
            psck[g] <= sck[g];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_pop(input string tag, input int g);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_inst"},  32'(g), 32'(e.g));
            check({tag, "_data"},  dat_o[g], e.data);
            check({tag, "_frame"}, frame[g], e.frame);
        end
    endtask

    // Called right after a falling edge; that clock period is cycle 0.
    task automatic do_read(input string tag, input int g, input logic [31:0] a,
                           input int drop_at, input int rst_at,
                           input int exp_cyc, input int exp_rises);
        int          ack_at, r0, a0, e0;
        logic [31:0] d0;
        r0 = rises[g]; a0 = acks[g]; e0 = errs[g]; d0 = dat_o[g]; ack_at = -1;
        if (exp_cyc > 0) sb.push_back('{g, {8'h03, a[23:2], 2'b00}, exp_word(a)});
        adr[g] = a; we[g] = 1'b0; cyc[g] = 1'b1; stb[g] = 1'b1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (i == drop_at) begin
                cyc[g] = 1'b0; stb[g] = 1'b0;
            end
            if (i == rst_at) rst = 1'b1;
            if (rst_at > 0 && i == rst_at + 1) begin
                check({tag, "_rst_csn"}, 32'(csn[g]), 32'd1);
                check({tag, "_rst_sck"}, 32'(sck[g]), 32'd0);
                rst = 1'b0; cyc[g] = 1'b0; stb[g] = 1'b0;
            end
            if (ack[g] && ack_at < 0) begin
                ack_at = i;
                check({tag, "_csn_at_ack"}, 32'(csn[g]), 32'd1);
                check_pop(tag, g);
                cyc[g] = 1'b0; stb[g] = 1'b0;
            end
        end
        check({tag, "_ack_cycle"}, 32'(ack_at), 32'(exp_cyc));
        check({tag, "_ack_count"}, 32'(acks[g] - a0), (exp_cyc > 0) ? 32'd1 : 32'd0);
        check({tag, "_err_count"}, 32'(errs[g] - e0), 32'd0);
        check({tag, "_mosi_data_phase"}, 32'(mosi_hi[g]), 32'd0);
        if (exp_rises >= 0) check({tag, "_sck_rises"}, 32'(rises[g] - r0), 32'(exp_rises));
        if (exp_cyc < 0 && rst_at < 0) check({tag, "_dat_held"}, dat_o[g], d0);
        if (rst_at > 0) check({tag, "_dat_after_rst"}, dat_o[g], 32'h0);
    endtask

    initial begin
        int r0, a0, e0, a1, a2, run, gap;
        rst = 1'b1; adr = '0; wdat = 32'h1234_5678; sel = 4'hF;
        we = '0; cyc = '0; stb = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst%0d_ack", g),  32'(ack[g]),  32'd0);
            check($sformatf("rst%0d_err", g),  32'(err[g]),  32'd0);
            check($sformatf("rst%0d_dat", g),  dat_o[g],     32'h0);
            check($sformatf("rst%0d_sck", g),  32'(sck[g]),  32'd0);
            check($sformatf("rst%0d_csn", g),  32'(csn[g]),  32'd1);
            check($sformatf("rst%0d_mosi", g), 32'(mosi[g]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Plain read, then the same word through an unaligned byte address.
        do_read("rd104", 0, 32'h0000_0104, -1, -1, 257, 64);
        check("rd104_word", dat_o[0], 32'hDEAD_BEEF);
        do_read("rd107", 0, 32'h0000_0107, -1, -1, 257, 64);
        check("rd107_word", dat_o[0], 32'hDEAD_BEEF);

        // Write: err pulse in cycle 1, no SPI activity, no ack.
        r0 = rises[0]; a0 = acks[0]; e0 = errs[0];
        adr[0] = 32'h10; we[0] = 1'b1; cyc[0] = 1'b1; stb[0] = 1'b1;
        @(negedge clk);
        check("wr_err_c1", 32'(err[0]), 32'd1);
        check("wr_csn_c1", 32'(csn[0]), 32'd1);
        check("wr_ack_c1", 32'(ack[0]), 32'd0);
        we[0] = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clk);
        check("wr_err_c2", 32'(err[0]), 32'd0);
        repeat (20) @(negedge clk);
        check("wr_err_count", 32'(errs[0] - e0), 32'd1);
        check("wr_ack_count", 32'(acks[0] - a0), 32'd0);
        check("wr_sck_rises", 32'(rises[0] - r0), 32'd0);

        // Master abandons the cycle mid-frame: frame completes, nothing returned.
        do_read("drop", 0, 32'h0000_0200, 40, -1, -1, 64);

        // Reset mid-frame, then a fresh read must still be correct.
        do_read("rstmid", 0, 32'h0000_0104, -1, 100, -1, -1);
        do_read("rd008", 0, 32'h0000_0008, -1, -1, 257, 64);
        check("rd008_word", dat_o[0], 32'hAEAF_ACAD);

        // Back-to-back reads at CLK_DIV=1 with stb held between them.
        sb.push_back('{1, 32'h0300_0000, exp_word(32'h0)});
        sb.push_back('{1, 32'h0300_0004, exp_word(32'h4)});
        a1 = -1; a2 = -1; run = 0; gap = -1;
        adr[1] = 32'h0; we[1] = 1'b0; cyc[1] = 1'b1; stb[1] = 1'b1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (a1 > 0 && a2 < 0 && gap < 0) begin
                if (csn[1]) run++;
                else gap = run;
            end
            if (ack[1]) begin
                if (a1 < 0) begin
                    a1 = i;
                    run = 1;
                    check_pop("b2b_first", 1);
                    adr[1] = 32'h4;
                end else if (a2 < 0) begin
                    a2 = i;
                    check_pop("b2b_second", 1);
                    cyc[1] = 1'b0; stb[1] = 1'b0;
                end
            end
        end
        check("b2b_ack1_cycle", 32'(a1), 32'd129);
        check("b2b_ack2_cycle", 32'(a2), 32'd259);
        check("b2b_csn_gap_ge1", 32'(gap >= 1), 32'd1);
        check("b2b_sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
